dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single 16-bit × 64K data memory between the pipeline MEM stage (port A) and the program/data loader (port B). It issues at most one memory operation per cycle and stalls the pipeline when B wins. It bounds B's wait with a starvation counter and supports short locked bursts from B. It returns registered read data with a one-cycle latency. It sits between the MEM stage, the loader and the memory array.

## Interface
- MAX_WAIT, 4: consecutive cycles B may wait before it is forced to priority; 0 means B wins whenever it requests.
- MAX_BURST, 8: maximum consecutive B grants under LOCK_B before A is given one cycle.
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- OP_A  in  2  pipeline op: 2'b10 = read, 2'b11 = write, other values = no memory request.
- ADDR_A, WDATA_A  in  16 each  pipeline address and write data.
- REQ_B, WE_B, LOCK_B  in  1 each  loader request, write enable and burst lock.
- ADDR_B, WDATA_B  in  16 each  loader address and write data.
- GNT_A, GNT_B  out  1 each  combinational grant; the access occurs in this cycle.
- STALL_A  out  1  asserted when OP_A[1] = 1 and GNT_A = 0.
- MEM_EN, MEM_WE  out  1 each  memory strobe and write enable.
- MEM_ADDR, MEM_WDATA  out  16 each  muxed address and write data to the array.
- MEM_RDATA  in  16  combinational read data from the array.
- RDATA  out  16  registered read data.
- RVALID_A, RVALID_B  out  1 each  qualifies RDATA for the owner of last cycle's read.

## Operation
- Requests:
  - A requests when OP_A[1] = 1.
  - B requests when REQ_B = 1.
  - GNT_A and GNT_B are never both 1.
  - With no request: MEM_EN = 0, and MEM_ADDR/MEM_WDATA are 0.
- States:
  - A_PRI (reset state): A wins on a conflict.
  - B_PRI: B wins the next conflict.
  - B_BURST: B holds the memory while LOCK_B is asserted.
- Transitions:
  - A_PRI → B_PRI when wait_cnt reaches MAX_WAIT and B is still requesting.
  - B_PRI → B_BURST on a B grant with LOCK_B = 1.
  - B_PRI → A_PRI on a B grant with LOCK_B = 0.
  - B_BURST → A_PRI when REQ_B = 0, LOCK_B = 0, or burst_cnt = MAX_BURST.
  - On the burst_cnt = MAX_BURST exit, A gets the next cycle even if B requests.
- wait_cnt:
  - 4 bits; increments each cycle B requests without a grant; saturates at MAX_WAIT.
  - Clears on GNT_B or when REQ_B = 0.
- burst_cnt:
  - 4 bits; counts B grants in B_BURST.
  - Clears on entry to B_BURST and on leaving it.
- An uncontested requester is always granted in the same cycle, in any state.
- B handshake:
  - Once REQ_B is asserted, ADDR_B, WE_B, WDATA_B and LOCK_B stay stable until the cycle GNT_B = 1.
  - REQ_B may drop the cycle after the grant.
- A is held by the pipeline while STALL_A = 1; the arbiter keeps no copy of A's request.
- Read data:
  - A granted read (A with OP_A = 2'b10, or B with WE_B = 0) registers MEM_RDATA into RDATA.
  - It then pulses the owner's RVALID for exactly one cycle.
  - RDATA holds its value until the next read.
- Writes produce no RVALID.

## Timing
- Grant and memory outputs are combinational from the registered state and the current inputs.
- Read latency: request granted in cycle N, RDATA/RVALID valid in cycle N+1.
- Back-to-back reads from either port give one RVALID per cycle.
- Throughput: one access per cycle.
- Reset values:
  - State = A_PRI; wait_cnt = 0; burst_cnt = 0.
  - RDATA = 0; RVALID_A = RVALID_B = 0.
  - GNT/STALL/MEM outputs follow their combinational rules with state = A_PRI.
- Reset mid-operation: a read granted in the cycle RESET rises produces no RVALID, and any burst is abandoned.
- Simultaneous events:
  - wait_cnt reaching MAX_WAIT in the same cycle B is granted: the grant wins; clear the counter and stay in A_PRI.
  - LOCK_B dropping on the last permitted burst beat: exit to A_PRI.

## Structure
- Shared package holds:
  - OP encodings OP_NOP, OP_READ = 2'b10, OP_WRITE = 2'b11, shared with the MEM stage.
  - The state enum {A_PRI, B_PRI, B_BURST}.
  - A 16-bit data/address width constant.
- One sub-module, arb_rdata_reg: the RDATA register and the RVALID_A/RVALID_B pulse logic, with asynchronous reset.
- The FSM, the counters and the grant mux live in dmem_arbiter.

## Test plan
- Reset, then A read at ADDR_A = 16'h0010 (memory holds 16'hBEEF) with no B → GNT_A in the same cycle, STALL_A = 0, next cycle RDATA = 16'hBEEF and RVALID_A = 1.
- A and B both request continuously, MAX_WAIT = 4 → A is granted for 4 cycles, B on cycle 5 with STALL_A = 1 for that one cycle, then A resumes.
- MAX_WAIT = 0, B write 16'h1234 to 16'h0020 against an A read of 16'h0020 → B is granted first; A's read then returns 16'h1234 with RVALID_A.
- B burst with LOCK_B = 1 against continuous A requests, MAX_BURST = 8 → 8 consecutive GNT_B, then one GNT_A, then B is re-arbitrated.
- RESET asserted in the cycle of a granted B read → no RVALID_B; after release, state = A_PRI and RDATA = 0.
- A write (OP_A = 2'b11) and B idle → MEM_WE = 1 with no RVALID; OP_A = 2'b00 with REQ_B = 0 → MEM_EN = 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the MEM stage that drives port A.
// Holds the op encodings, the arbitration state type and the word width.
package dmem_arbiter_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b11;

    typedef enum logic [1:0] {
        A_PRI   = 2'd0,
        B_PRI   = 2'd1,
        B_BURST = 2'd2
    } arb_state_e;

    // Any op with the top bit set touches memory.
    function automatic logic op_is_req(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/dmem_arbiter_rdata_reg.sv
// Registered read-data return path: captures the array output on a granted read
// and pulses the RVALID of whichever port owned that read.
module arb_rdata_reg
    import dmem_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  rd_a,
    input  logic  rd_b,
    input  word_t mem_rdata,
    output word_t rdata,
    output logic  rvalid_a,
    output logic  rvalid_b
);

    word_t rdata_q, rdata_d;
    logic  rvalid_a_q, rvalid_a_d;
    logic  rvalid_b_q, rvalid_b_d;

    always_comb begin
        rdata_d    = rdata_q;
        rvalid_a_d = rd_a;
        rvalid_b_d = rd_b;
        if (rd_a || rd_b) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage (A) and the
// loader (B): one access per cycle, starvation-bounded B, locked B bursts.
//
// state   | meaning
// A_PRI   | A wins a conflict; wait_cnt tracks how long B has been refused
// B_PRI   | B wins the next conflict
// B_BURST | B keeps the memory while LOCK_B holds, up to MAX_BURST beats
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [1:0]  OP_A,
    input  logic [15:0] ADDR_A,
    input  logic [15:0] WDATA_A,
    input  logic        REQ_B,
    input  logic        WE_B,
    input  logic        LOCK_B,
    input  logic [15:0] ADDR_B,
    input  logic [15:0] WDATA_B,
    output logic        GNT_A,
    output logic        GNT_B,
    output logic        STALL_A,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    input  logic [15:0] MEM_RDATA,
    output logic [15:0] RDATA,
    output logic        RVALID_A,
    output logic        RVALID_B
);

    localparam logic [3:0] WAIT_LIM   = 4'(MAX_WAIT);
    // The burst's first beat is granted in B_PRI, so B_BURST itself allows one fewer.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
    localparam bit         B_FIRST    = (MAX_WAIT == 0);
    localparam bit         BURST_OK   = (MAX_BURST > 1);

    arb_state_e state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;

    logic  req_a, req_b;
    logic  gnt_a, gnt_b;
    logic  burst_last;
    logic  mem_en, mem_we;
    word_t mem_addr, mem_wdata;
    logic  rd_a, rd_b;

    assign req_a = op_is_req(OP_A);
    assign req_b = REQ_B;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q     <= A_PRI;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        burst_last  = gnt_b && ((burst_cnt_q + 4'd1) == BURST_LAST);

        if (gnt_b || !req_b) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LIM) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        case (state_q)
            A_PRI: begin
                if (req_b && !gnt_b && (wait_cnt_d == WAIT_LIM)) begin
                    state_d = B_PRI;
                end
            end
            B_PRI: begin
                if (gnt_b) begin
                    state_d     = (LOCK_B && BURST_OK) ? B_BURST : A_PRI;
                    burst_cnt_d = '0;
                end
            end
            B_BURST: begin
                // Leaving to A_PRI hands A the following cycle even if B still asks.
                if (!req_b || !LOCK_B || burst_last) begin
                    state_d     = A_PRI;
                    burst_cnt_d = '0;
                end else if (gnt_b) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d     = A_PRI;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            B_PRI, B_BURST: begin
                gnt_b = req_b;
                gnt_a = req_a && !req_b;
            end
            default: begin
                gnt_a = req_a && !(B_FIRST && req_b);
                gnt_b = req_b && !gnt_a;
            end
        endcase

        if (gnt_a) begin
            mem_en    = 1'b1;
            mem_we    = OP_A[0];
            mem_addr  = ADDR_A;
            mem_wdata = WDATA_A;
        end else if (gnt_b) begin
            mem_en    = 1'b1;
            mem_we    = WE_B;
            mem_addr  = ADDR_B;
            mem_wdata = WDATA_B;
        end
    end

    assign rd_a = gnt_a && (OP_A == OP_READ);
    assign rd_b = gnt_b && !WE_B;

    assign GNT_A     = gnt_a;
    assign GNT_B     = gnt_b;
    assign STALL_A   = req_a && !gnt_a;
    assign MEM_EN    = mem_en;
    assign MEM_WE    = mem_we;
    assign MEM_ADDR  = mem_addr;
    assign MEM_WDATA = mem_wdata;

    arb_rdata_reg u_rdata (
        .clk       (CLOCK_50),
        .rst       (RESET),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .mem_rdata (MEM_RDATA),
        .rdata     (RDATA),
        .rvalid_a  (RVALID_A),
        .rvalid_b  (RVALID_B)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a default instance (MAX_WAIT=4, MAX_BURST=8) and a
// MAX_WAIT=0 instance, each with its own memory array; reads are scoreboarded.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    typedef struct packed {
        logic        is_b;
        logic [15:0] data;
    } rd_exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  op_a;
    logic [15:0] addr_a, wdata_a;
    logic        req_b, we_b, lock_b;
    logic [15:0] addr_b, wdata_b;

    logic        gnt_a, gnt_b, stall_a, mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, rdata;
    logic        rvalid_a, rvalid_b;

    logic        gnt_a_z, gnt_b_z, stall_a_z, mem_en_z, mem_we_z;
    logic [15:0] mem_addr_z, mem_wdata_z, mem_rdata_z, rdata_z;
    logic        rvalid_a_z, rvalid_b_z;

    logic [15:0] mem  [65536];
    logic [15:0] mem0 [65536];
    logic        pl_en;
    logic [15:0] pl_addr, pl_data;

    logic [15:0] shadow [logic [15:0]];
    rd_exp_t     exp_q[$];
    rd_exp_t     exp0_q[$];

    int vectors;
    int miscompares;

    dmem_arbiter dut (
        .CLOCK_50(clk), .RESET(rst),
        .OP_A(op_a), .ADDR_A(addr_a), .WDATA_A(wdata_a),
        .REQ_B(req_b), .WE_B(we_b), .LOCK_B(lock_b), .ADDR_B(addr_b), .WDATA_B(wdata_b),
        .GNT_A(gnt_a), .GNT_B(gnt_b), .STALL_A(stall_a),
        .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
        .MEM_RDATA(mem_rdata), .RDATA(rdata), .RVALID_A(rvalid_a), .RVALID_B(rvalid_b)
    );

    dmem_arbiter #(.MAX_WAIT(0), .MAX_BURST(8)) dut0 (
        .CLOCK_50(clk), .RESET(rst),
        .OP_A(op_a), .ADDR_A(addr_a), .WDATA_A(wdata_a),
        .REQ_B(req_b), .WE_B(we_b), .LOCK_B(lock_b), .ADDR_B(addr_b), .WDATA_B(wdata_b),
        .GNT_A(gnt_a_z), .GNT_B(gnt_b_z), .STALL_A(stall_a_z),
        .MEM_EN(mem_en_z), .MEM_WE(mem_we_z), .MEM_ADDR(mem_addr_z), .MEM_WDATA(mem_wdata_z),
        .MEM_RDATA(mem_rdata_z), .RDATA(rdata_z), .RVALID_A(rvalid_a_z), .RVALID_B(rvalid_b_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr];
    assign mem_rdata_z = mem0[mem_addr_z];

    always @(posedge clk) begin
        if (pl_en)                 mem[pl_addr] <= pl_data;
        else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end

    always @(posedge clk) begin
        if (pl_en)                     mem0[pl_addr] <= pl_data;
        else if (mem_en_z && mem_we_z) mem0[mem_addr_z] <= mem_wdata_z;
    end

    function automatic logic [15:0] shadow_rd(input logic [15:0] a);
        return shadow.exists(a) ? shadow[a] : 16'h0000;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        shadow[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic idle_inputs();
        op_a = OP_NOP; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; lock_b = 1'b0; addr_b = '0; wdata_b = '0;
    endtask

    // One cycle on the main instance: inputs already driven at posedge+1.
    task automatic cyc(input string tag, input bit exp_ga, input bit exp_gb);
        rd_exp_t e;
        bit ea, eb;
        ea = 1'b0; eb = 1'b0; e = '0;
        #3;
        vectors++;
        if (gnt_a !== exp_ga || gnt_b !== exp_gb) begin
            miscompares++;
            $display("FAIL %s grant: got a=%0b b=%0b want a=%0b b=%0b", tag, gnt_a, gnt_b, exp_ga, exp_gb);
        end
        vectors++;
        if (stall_a !== (op_a[1] && !exp_ga)) begin
            miscompares++;
            $display("FAIL %s stall_a: got %0b want %0b", tag, stall_a, op_a[1] && !exp_ga);
        end
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ea = !e.is_b;
            eb = e.is_b;
        end
        vectors++;
        if (rvalid_a !== ea || rvalid_b !== eb) begin
            miscompares++;
            $display("FAIL %s rvalid: got a=%0b b=%0b want a=%0b b=%0b", tag, rvalid_a, rvalid_b, ea, eb);
        end
        if (ea || eb) begin
            vectors++;
            if (rdata !== e.data) begin
                miscompares++;
                $display("FAIL %s rdata: got %h want %h", tag, rdata, e.data);
            end
        end
        if (exp_ga) begin
            if (op_a == OP_READ) begin
                e.is_b = 1'b0; e.data = shadow_rd(addr_a); exp_q.push_back(e);
            end else begin
                shadow[addr_a] = wdata_a;
            end
        end
        if (exp_gb) begin
            if (!we_b) begin
                e.is_b = 1'b1; e.data = shadow_rd(addr_b); exp_q.push_back(e);
            end else begin
                shadow[addr_b] = wdata_b;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        vectors++;
        if (rdata !== 16'h0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_regs: got rdata=%h rva=%0b rvb=%0b want 0000 0 0", rdata, rvalid_a, rvalid_b);
        end
        vectors++;
        if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_idle: got ga=%0b gb=%0b en=%0b addr=%h want 0 0 0 0000", gnt_a, gnt_b, mem_en, mem_addr);
        end
        op_a = OP_READ; addr_a = 16'h0010;
        #1;
        vectors++;
        if (gnt_a !== 1'b1 || mem_addr !== 16'h0010 || stall_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_comb_grant: got ga=%0b addr=%h stall=%0b want 1 0010 0", gnt_a, mem_addr, stall_a);
        end
        // Read granted while reset is held must not return a valid.
        @(posedge clk); #1;
        op_a = OP_NOP; addr_a = '0;
        rst = 1'b0;
    endtask

    task automatic test_a_read();
        op_a = OP_READ; addr_a = 16'h0010;
        #1;
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
            miscompares++;
            $display("FAIL a_read_mem: got en=%0b we=%0b addr=%h want 1 0 0010", mem_en, mem_we, mem_addr);
        end
        cyc("a_read", 1'b1, 1'b0);
        idle_inputs();
        cyc("a_read_ret", 1'b0, 1'b0);
    endtask

    task automatic test_contention();
        logic [9:0]  pat;
        logic [15:0] ai, bi;
        pat = 10'b10_0001_0000;
        ai = '0; bi = '0;
        op_a = OP_READ; req_b = 1'b1; we_b = 1'b0; lock_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            addr_a = 16'h0100 + ai;
            addr_b = 16'h0200 + bi;
            cyc($sformatf("contend%0d", i), !pat[i], pat[i]);
            if (pat[i]) bi = bi + 16'd1;
            else        ai = ai + 16'd1;
        end
        idle_inputs();
        cyc("contend_drain", 1'b0, 1'b0);
    endtask

    task automatic test_burst();
        logic [16:0] pat;
        logic [15:0] ai, bi;
        pat = 17'b1_0000_1111_1111_0000;
        ai = '0; bi = '0;
        op_a = OP_READ; req_b = 1'b1; we_b = 1'b0; lock_b = 1'b1;
        for (int i = 0; i < 17; i++) begin
            addr_a = 16'h0140 + ai;
            addr_b = 16'h0300 + bi;
            cyc($sformatf("burst%0d", i), !pat[i], pat[i]);
            if (pat[i]) bi = bi + 16'd1;
            else        ai = ai + 16'd1;
        end
        idle_inputs();
        cyc("burst_drain", 1'b0, 1'b0);
        cyc("burst_drain2", 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] ai;
        rd_exp_t     e;
        ai = '0;
        op_a = OP_READ; req_b = 1'b1; we_b = 1'b0; lock_b = 1'b1;
        addr_b = 16'h0340;
        for (int i = 0; i < 4; i++) begin
            addr_a = 16'h0180 + ai;
            cyc($sformatf("rmid_a%0d", i), 1'b1, 1'b0);
            ai = ai + 16'd1;
        end
        addr_a = 16'h0180 + ai;
        cyc("rmid_b_entry", 1'b0, 1'b1);
        addr_b = 16'h0341;
        #3;
        vectors++;
        if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_burst_grant: got a=%0b b=%0b want a=0 b=1", gnt_a, gnt_b);
        end
        e = exp_q.pop_front();
        vectors++;
        if (rvalid_b !== 1'b1 || rdata !== e.data) begin
            miscompares++;
            $display("FAIL rmid_entry_ret: got rvb=%0b rdata=%h want 1 %h", rvalid_b, rdata, e.data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || rdata !== 16'h0) begin
            miscompares++;
            $display("FAIL rmid_no_rvalid: got rva=%0b rvb=%0b rdata=%h want 0 0 0000", rvalid_a, rvalid_b, rdata);
        end
        rst = 1'b0;
        cyc("rmid_post_a_pri", 1'b1, 1'b0);
        idle_inputs();
        cyc("rmid_drain", 1'b0, 1'b0);
    endtask

    task automatic test_wait0();
        rd_exp_t e;
        op_a = OP_READ; addr_a = 16'h0020;
        req_b = 1'b1; we_b = 1'b1; lock_b = 1'b0; addr_b = 16'h0020; wdata_b = 16'h1234;
        #3;
        vectors++;
        if (gnt_b_z !== 1'b1 || gnt_a_z !== 1'b0 || stall_a_z !== 1'b1) begin
            miscompares++;
            $display("FAIL w0_b_first: got ga=%0b gb=%0b stall=%0b want 0 1 1", gnt_a_z, gnt_b_z, stall_a_z);
        end
        vectors++;
        if (mem_we_z !== 1'b1 || mem_addr_z !== 16'h0020 || mem_wdata_z !== 16'h1234) begin
            miscompares++;
            $display("FAIL w0_b_write: got we=%0b addr=%h wd=%h want 1 0020 1234", mem_we_z, mem_addr_z, mem_wdata_z);
        end
        @(posedge clk); #1;
        req_b = 1'b0; we_b = 1'b0; wdata_b = '0;
        #3;
        vectors++;
        if (gnt_a_z !== 1'b1 || rvalid_a_z !== 1'b0 || rvalid_b_z !== 1'b0) begin
            miscompares++;
            $display("FAIL w0_a_next: got ga=%0b rva=%0b rvb=%0b want 1 0 0", gnt_a_z, rvalid_a_z, rvalid_b_z);
        end
        e.is_b = 1'b0; e.data = 16'h1234; exp0_q.push_back(e);
        @(posedge clk); #1;
        idle_inputs();
        #3;
        e = exp0_q.pop_front();
        vectors++;
        if (rvalid_a_z !== 1'b1 || rdata_z !== e.data) begin
            miscompares++;
            $display("FAIL w0_a_ret: got rva=%0b rdata=%h want 1 %h", rvalid_a_z, rdata_z, e.data);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_idle();
        op_a = OP_WRITE; addr_a = 16'h0030; wdata_a = 16'h5A5A;
        #1;
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0030 || mem_wdata !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL a_write_mem: got en=%0b we=%0b addr=%h wd=%h want 1 1 0030 5a5a", mem_en, mem_we, mem_addr, mem_wdata);
        end
        cyc("a_write", 1'b1, 1'b0);
        idle_inputs();
        #1;
        vectors++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            miscompares++;
            $display("FAIL nop_mem: got en=%0b we=%0b addr=%h wd=%h want 0 0 0000 0000", mem_en, mem_we, mem_addr, mem_wdata);
        end
        cyc("nop_after_write", 1'b0, 1'b0);
        op_a = OP_READ; addr_a = 16'h0030;
        cyc("readback", 1'b1, 1'b0);
        idle_inputs();
        cyc("readback_ret", 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        idle_inputs();
        @(posedge clk); #1;
        preload(16'h0010, 16'hBEEF);
        preload(16'h0020, 16'hAAAA);
        preload(16'h0030, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            preload(16'(16'h0100 + i), 16'(16'hA100 + i * 3));
            preload(16'(16'h0140 + i), 16'(16'hA400 + i * 5));
            preload(16'(16'h0200 + i), 16'(16'hB200 + i * 7));
            preload(16'(16'h0300 + i), 16'(16'hC300 + i * 9));
        end
        for (int i = 0; i < 8; i++) begin
            preload(16'(16'h0180 + i), 16'(16'hD180 + i));
            preload(16'(16'h0340 + i), 16'(16'hE340 + i));
        end

        test_reset();
        test_a_read();
        test_contention();
        test_burst();
        test_reset_mid();
        test_wait0();
        test_write_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
